replay_buffer_seq: RTL

Parametrised, sequence-numbered replay buffer for the data link layer transmit path. It stores each outgoing packet with an auto-assigned sequence number and presents packets to the link through a valid/ready handshake. Each packet is held until it is acknowledged. On a NAK or a replay timeout, every unacknowledged packet is retransmitted from the oldest one.

---
 rtl/replay_buffer_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/replay_buffer_seq.sv
// Sequence-numbered transmit replay buffer: holds packets until ACKed and rewinds on NAK/timeout (optional REPLAY_TIMER_EN internal timer).
// tx_valid one cycle after write, tx_data/tx_seq combinational; writes dropped while full, link stalls via tx_ready.
module replay_buffer_seq #(
  parameter int DATA_W       = 129,
  parameter int ADDR_W       = 3,
  parameter int SEQ_W        = 12,
  parameter int REPLAY_LIMIT = 4,
  parameter int TIMER_MAX    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [SEQ_W-1:0]  wr_seq,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [SEQ_W-1:0]  tx_seq,
  input  logic              ack,
  input  logic              nak,
  input  logic [SEQ_W-1:0]  ack_seq,
  input  logic              tim_out,
  output logic              replay_active,
  output logic [1:0]        replay_num,
  output logic              replay_rollover,
  output logic              ack_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] head, tail, send_ptr;
  logic [CW-1:0]     count_q, send_off, sent_hw, rep_end;
  logic [SEQ_W-1:0]  head_seq, wr_seq_q;
  logic              rep_act, roll_q, aerr_q;
  logic [1:0]        rep_num;

  logic              xfer, cmd, purge_ok, dup, err, wr_ok, trig, tmr_exp;
  logic [SEQ_W-1:0]  d;
  logic [CW-1:0]     purge_n, send1, hw1, count_nx, send_nx, hw_nx, end_nx;
  logic              act_nx, roll_nx;
  logic [1:0]        num_base, num_nx;

  // Send position, high-water mark and replay end are offsets from head so
  // a full buffer with everything sent is unambiguous.
  assign send_ptr        = head + send_off[ADDR_W-1:0];
  assign tx_valid        = send_off < count_q;
  assign tx_data         = mem[send_ptr];
  assign tx_seq          = head_seq + SEQ_W'(send_off);
  assign count           = count_q;
  assign full            = count_q == CW'(DEPTH);
  assign empty           = count_q == '0;
  assign wr_seq          = wr_seq_q;
  assign replay_active   = rep_act;
  assign replay_num      = rep_num;
  assign replay_rollover = roll_q;
  assign ack_err         = aerr_q;

  always_comb begin
    xfer     = tx_valid && tx_ready;
    cmd      = ack || nak;
    d        = ack_seq - head_seq;
    purge_ok = cmd && (d < SEQ_W'(sent_hw));
    dup      = cmd && (d == '1);
    err      = cmd && !purge_ok && !dup;
    purge_n  = purge_ok ? CW'(d) + CW'(1) : '0;
    wr_ok    = we && !full;
    send1    = send_off + CW'(xfer);
    hw1      = (send1 > sent_hw) ? send1 : sent_hw;
    count_nx = count_q - purge_n + CW'(wr_ok);
    trig     = (tim_out || tmr_exp || (nak && !err)) && (count_nx != '0);
    num_base = purge_ok ? 2'd0 : rep_num;
    // A purge may overtake the send position during a replay; clamp to head.
    send_nx  = (send1 > purge_n) ? send1 - purge_n : '0;
    hw_nx    = hw1 - purge_n;
    end_nx   = (rep_end > purge_n) ? rep_end - purge_n : '0;
    act_nx   = rep_act && !(xfer && (send1 == rep_end)) && (rep_end > purge_n);
    num_nx   = num_base;
    roll_nx  = 1'b0;
    if (trig) begin
      send_nx = '0;
      end_nx  = count_nx;
      act_nx  = 1'b1;
      if (num_base == 2'(REPLAY_LIMIT - 1)) begin
        num_nx  = 2'd0;
        roll_nx = 1'b1;
      end else begin
        num_nx = num_base + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      send_off <= '0;
      sent_hw  <= '0;
      rep_end  <= '0;
      head_seq <= '0;
      wr_seq_q <= '0;
      rep_act  <= 1'b0;
      rep_num  <= 2'd0;
      roll_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      head     <= head + purge_n[ADDR_W-1:0];
      head_seq <= head_seq + SEQ_W'(purge_n);
      count_q  <= count_nx;
      send_off <= send_nx;
      sent_hw  <= hw_nx;
      rep_end  <= end_nx;
      rep_act  <= act_nx;
      rep_num  <= num_nx;
      roll_q   <= roll_nx;
      aerr_q   <= err;
      if (wr_ok) begin
        tail     <= tail + 1'b1;
        wr_seq_q <= wr_seq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[tail] <= din;
  end

`ifdef REPLAY_TIMER_EN
  localparam int TW = $clog2(TIMER_MAX + 1);
  logic [TW-1:0] tmr;

  assign tmr_exp = (tmr == TW'(TIMER_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    tmr <= '0;
    else if (purge_ok || trig || count_q == '0)   tmr <= '0;
    else                                          tmr <= tmr + 1'b1;
  end
`else
  assign tmr_exp = (TIMER_MAX < 0);
`endif

endmodule
